// File: rtl/isqrt_rr_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency pipelined isqrt.
// Define ISQRT_ARB_STATS_EN to build the per-requester handshake counters.
module isqrt_rr_arbiter #(
  parameter int ISQRT_LAT = 4,
  parameter int DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_vld,
  input  logic [31:0] req0_x,
  output logic        req0_rdy,
  input  logic        req1_vld,
  input  logic [31:0] req1_x,
  output logic        req1_rdy,
  output logic        rsp0_vld,
  output logic [15:0] rsp0_y,
  output logic        rsp1_vld,
  output logic [15:0] rsp1_y,
  output logic        isqrt_x_vld,
  output logic [31:0] isqrt_x,
  input  logic        isqrt_y_vld,
  input  logic [15:0] isqrt_y,
  output logic        err,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < ISQRT_LAT + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("DEPTH must be a power of two and at least ISQRT_LAT+1");
  end

  typedef enum logic {PRI0, PRI1} pri_e;
  pri_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wp_q, rp_q;
  logic [DEPTH-1:0] tag_q;
  logic             xv_q;
  logic [31:0]      x_q;
  logic [15:0]      y0_q, y1_q;
  logic             err_q;
  logic             credit, hs0, hs1, hs, pop, tag;

  // Credit ignores a same-cycle pop so rdy never depends on isqrt_y_vld.
  assign credit = (cnt_q < CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PRI0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req0_rdy = credit & req0_vld & (~req1_vld | (state_q == PRI0));
    req1_rdy = credit & req1_vld & (~req0_vld | (state_q == PRI1));
    if (req0_rdy)      state_d = PRI1;
    else if (req1_rdy) state_d = PRI0;
  end

  assign hs0 = req0_rdy;
  assign hs1 = req1_rdy;
  assign hs  = hs0 | hs1;
  assign pop = isqrt_y_vld & (cnt_q != '0);
  assign tag = tag_q[rp_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      tag_q <= '0;
      xv_q  <= 1'b0;
      x_q   <= '0;
      y0_q  <= '0;
      y1_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      xv_q  <= hs;
      if (hs) begin
        tag_q[wp_q] <= hs1;
        wp_q        <= wp_q + AW'(1);
        x_q         <= hs1 ? req1_x : req0_x;
      end
      if (pop) rp_q <= rp_q + AW'(1);
      y0_q  <= rsp0_y;
      y1_q  <= rsp1_y;
      err_q <= err_q | (isqrt_y_vld & (cnt_q == '0));
    end
  end

  assign isqrt_x_vld = xv_q;
  assign isqrt_x     = x_q;
  assign rsp0_vld    = pop & ~tag;
  assign rsp1_vld    = pop & tag;
  assign rsp0_y      = rsp0_vld ? isqrt_y : y0_q;
  assign rsp1_y      = rsp1_vld ? isqrt_y : y1_q;
  assign err         = err_q;

`ifdef ISQRT_ARB_STATS_EN
  logic [15:0] gnt0_q, gnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q <= '0;
      gnt1_q <= '0;
    end else begin
      gnt0_q <= gnt0_q + 16'(hs0);
      gnt1_q <= gnt1_q + 16'(hs1);
    end
  end

  assign gnt_cnt0 = gnt0_q;
  assign gnt_cnt1 = gnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Scoreboard bench for isqrt_rr_arbiter with a behavioural fixed-latency isqrt model.
module tb_isqrt_rr_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_vld, req1_vld, req0_rdy, req1_rdy;
  logic [31:0] req0_x, req1_x;
  logic        rsp0_vld, rsp1_vld;
  logic [15:0] rsp0_y, rsp1_y;
  logic        isqrt_x_vld, isqrt_y_vld, err;
  logic [31:0] isqrt_x;
  logic [15:0] isqrt_y, gnt_cnt0, gnt_cnt1;

  logic        d4_r0v, d4_r1v, d4_r0r, d4_r1r, d4_rsp0v, d4_rsp1v, d4_xv, d4_yv, d4_err;
  logic [31:0] d4_r0x, d4_r1x, d4_x;
  logic [15:0] d4_rsp0y, d4_rsp1y, d4_y, d4_g0, d4_g1;

  logic        inj;
  logic [LAT:1] mv = '0;
  logic [31:0] mx [1:LAT];

  typedef struct { logic id; logic [15:0] y; int cyc; } sb_t;
  sb_t         sb_q[$];
  sb_t         e;
  logic [15:0] last_y0, last_y1;
  int          n_chk = 0, n_fail = 0, cyc = 0;
  int          n_rsp0, n_rsp1, hs0_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isqrt_rr_arbiter #(.ISQRT_LAT(LAT), .DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_x(req0_x), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_x(req1_x), .req1_rdy(req1_rdy),
    .rsp0_vld(rsp0_vld), .rsp0_y(rsp0_y), .rsp1_vld(rsp1_vld), .rsp1_y(rsp1_y),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .err(err), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  isqrt_rr_arbiter #(.ISQRT_LAT(3), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(d4_r0v), .req0_x(d4_r0x), .req0_rdy(d4_r0r),
    .req1_vld(d4_r1v), .req1_x(d4_r1x), .req1_rdy(d4_r1r),
    .rsp0_vld(d4_rsp0v), .rsp0_y(d4_rsp0y), .rsp1_vld(d4_rsp1v), .rsp1_y(d4_rsp1y),
    .isqrt_x_vld(d4_xv), .isqrt_x(d4_x),
    .isqrt_y_vld(d4_yv), .isqrt_y(d4_y),
    .err(d4_err), .gnt_cnt0(d4_g0), .gnt_cnt1(d4_g1)
  );

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [63:0] r = 0;
    for (int b = 15; b >= 0; b--) begin
      logic [63:0] t;
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  // Shared isqrt: results appear LAT cycles after issue; not reset with the DUT.
  always @(posedge clk) begin
    mv[1] <= isqrt_x_vld;
    mx[1] <= isqrt_x;
    for (int k = 2; k <= LAT; k++) begin
      mv[k] <= mv[k-1];
      mx[k] <= mx[k-1];
    end
  end
  assign isqrt_y_vld = mv[LAT] | inj;
  assign isqrt_y     = isqrt32(mx[LAT]);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: push on handshake, pop and compare on each response pulse.
  always @(negedge clk) begin
    chk("one_hs", {31'd0, req0_rdy & req1_rdy}, 0);
    chk("rsp_onehot", {31'd0, rsp0_vld & rsp1_vld}, 0);
    if (rsp0_vld || rsp1_vld) begin
      chk("rsp_unexpected", {31'd0, sb_q.size() == 0}, 0);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("rsp_id", {31'd0, rsp1_vld}, {31'd0, e.id});
        chk("rsp_y", {16'd0, rsp1_vld ? rsp1_y : rsp0_y}, {16'd0, e.y});
        chk("rsp_lat", cyc - e.cyc, LAT + 1);
      end
      if (rsp0_vld) begin last_y0 = rsp0_y; n_rsp0++; end
      if (rsp1_vld) begin last_y1 = rsp1_y; n_rsp1++; end
    end
    if (!rsp0_vld) chk("rsp0_hold", {16'd0, rsp0_y}, {16'd0, last_y0});
    if (!rsp1_vld) chk("rsp1_hold", {16'd0, rsp1_y}, {16'd0, last_y1});
    if (req0_vld && req0_rdy) begin sb_q.push_back('{1'b0, isqrt32(req0_x), cyc}); hs0_n++; end
    if (req1_vld && req1_rdy) sb_q.push_back('{1'b1, isqrt32(req1_x), cyc});
  end

  task automatic sb_clear();
    sb_q.delete();
    last_y0 = '0; last_y1 = '0;
    n_rsp0 = 0; n_rsp1 = 0; hs0_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_vld = 0; req1_vld = 0; d4_r0v = 0; d4_r1v = 0;
    rst_n = 0;
    sb_clear();
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0; inj = 0;
    req0_vld = 0; req1_vld = 0; req0_x = 0; req1_x = 0;
    d4_r0v = 0; d4_r1v = 0; d4_r0x = 32'd49; d4_r1x = 32'd64; d4_yv = 0; d4_y = 16'd5;
    sb_clear();
    idle(3);
    rst_n = 1;
    @(negedge clk);
    chk("rst_xvld", {31'd0, isqrt_x_vld}, 0);
    chk("rst_x", isqrt_x, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_gnt0", {16'd0, gnt_cnt0}, 0);

    // Single request from requester 0
    @(posedge clk); #1 req0_vld = 1; req0_x = 32'd144;
    @(negedge clk);
    chk("t1_rdy0", {31'd0, req0_rdy}, 1);
    chk("t1_rdy1", {31'd0, req1_rdy}, 0);
    @(posedge clk); #1 req0_vld = 0;
    @(negedge clk);
    chk("t1_xvld", {31'd0, isqrt_x_vld}, 1);
    chk("t1_x", isqrt_x, 144);
    idle(1);
    @(negedge clk);
    chk("t1_xvld_drop", {31'd0, isqrt_x_vld}, 0);
    chk("t1_x_hold", isqrt_x, 144);
    idle(LAT + 2);
    chk("t1_nrsp0", n_rsp0, 1);
    chk("t1_nrsp1", n_rsp1, 0);
    chk("t1_y0", {16'd0, rsp0_y}, 12);

    // Orphan result sets the sticky error
    do_reset();
    @(negedge clk);
    chk("t3_err0", {31'd0, err}, 0);
    @(posedge clk); #1 inj = 1;
    @(posedge clk); #1 inj = 0;
    @(negedge clk);
    chk("t3_err1", {31'd0, err}, 1);
    idle(5);
    chk("t3_err_hold", {31'd0, err}, 1);
    chk("t3_norsp", n_rsp0 + n_rsp1, 0);

    // Both requesters continuously valid: strict alternation from req0
    @(posedge clk); #1 req0_vld = 1; req1_vld = 1; req0_x = 32'd16; req1_x = 32'd81;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_rdy0", {31'd0, req0_rdy}, (i % 2 == 0) ? 1 : 0);
      chk("t2_rdy1", {31'd0, req1_rdy}, (i % 2 == 1) ? 1 : 0);
      @(posedge clk); #1;
    end
    req0_vld = 0; req1_vld = 0;
    idle(LAT + 3);
    chk("t2_nrsp0", n_rsp0, 4);
    chk("t2_nrsp1", n_rsp1, 4);
    chk("t2_y0", {16'd0, rsp0_y}, 4);
    chk("t2_y1", {16'd0, rsp1_y}, 9);
    chk("t2_err_hold", {31'd0, err}, 1);
`ifdef ISQRT_ARB_STATS_EN
    chk("t2_gnt0", {16'd0, gnt_cnt0}, 4);
    chk("t2_gnt1", {16'd0, gnt_cnt1}, 4);
`else
    chk("t2_gnt0", {16'd0, gnt_cnt0}, 0);
    chk("t2_gnt1", {16'd0, gnt_cnt1}, 0);
`endif

    // Asynchronous reset with three operations in flight
    @(posedge clk); #1 req0_vld = 1; req0_x = 32'd100;
    idle(3);
    req0_vld = 0;
    #1 rst_n = 0;
    sb_clear();
    #1;
    chk("t4_xvld", {31'd0, isqrt_x_vld}, 0);
    chk("t4_x", isqrt_x, 0);
    chk("t4_rsp0v", {31'd0, rsp0_vld}, 0);
    chk("t4_rsp1v", {31'd0, rsp1_vld}, 0);
    chk("t4_rsp0y", {16'd0, rsp0_y}, 0);
    chk("t4_rsp1y", {16'd0, rsp1_y}, 0);
    chk("t4_err", {31'd0, err}, 0);
    chk("t4_gnt0", {16'd0, gnt_cnt0}, 0);
    chk("t4_gnt1", {16'd0, gnt_cnt1}, 0);
    @(posedge clk); #1 rst_n = 1;
    idle(LAT + 3);
    chk("t4_stale_err", {31'd0, err}, 1);
    chk("t4_stale_norsp", n_rsp0 + n_rsp1, 0);
    req0_vld = 1; req1_vld = 1; req0_x = 32'd225; req1_x = 32'd1;
    @(negedge clk);
    chk("t4_first_rdy0", {31'd0, req0_rdy}, 1);
    chk("t4_first_rdy1", {31'd0, req1_rdy}, 0);
    @(posedge clk); #1 req0_vld = 0; req1_vld = 0;
    idle(LAT + 3);
    chk("t4_nrsp0", n_rsp0, 1);
    chk("t4_y0", {16'd0, rsp0_y}, 15);

    // DEPTH=4 instance with a stalled isqrt: credit exhaustion and recovery
    @(posedge clk); #1 d4_r0v = 1; d4_r1v = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_rdy", {31'd0, d4_r0r | d4_r1r}, 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_full_rdy0", {31'd0, d4_r0r}, 0);
      chk("t5_full_rdy1", {31'd0, d4_r1r}, 0);
      @(posedge clk); #1;
    end
    d4_yv = 1;
    @(negedge clk);
    chk("t5_pop_rdy", {31'd0, d4_r0r | d4_r1r}, 0);
    chk("t5_pop_rsp0", {31'd0, d4_rsp0v}, 1);
    chk("t5_pop_rsp0y", {16'd0, d4_rsp0y}, 5);
    @(posedge clk); #1 d4_yv = 0;
    @(negedge clk);
    chk("t5_back_rdy0", {31'd0, d4_r0r}, 1);
    chk("t5_back_rdy1", {31'd0, d4_r1r}, 0);
    @(posedge clk); #1 d4_r0v = 0; d4_r1v = 0;

    // 65537 back-to-back handshakes on req0: counter wraps to 1
    do_reset();
    req0_vld = 1;
    for (int i = 0; i < 65537; i++) begin
      req0_x = $urandom;
      @(posedge clk); #1;
    end
    req0_vld = 0;
    idle(LAT + 3);
    chk("t6_hs_total", hs0_n, 65537);
    chk("t6_nrsp0", n_rsp0, 65537);
`ifdef ISQRT_ARB_STATS_EN
    chk("t6_gnt0", {16'd0, gnt_cnt0}, 1);
`else
    chk("t6_gnt0", {16'd0, gnt_cnt0}, 0);
`endif
    chk("t6_gnt1", {16'd0, gnt_cnt1}, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/isqrt_rr_arbiter.md
ISQRT_RR_ARBITER -- requirements
Module: isqrt_rr_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Parameter ISQRT_LAT, default 4: fixed latency in cycles of the shared pipelined isqrt, from isqrt_x_vld to isqrt_y_vld.
REQ-003 Parameter DEPTH, default 8: maximum in-flight operations and tag FIFO depth; a power of two, no smaller than ISQRT_LAT+1.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0_vld / req1_vld  in  1  requester n has an operand.
REQ-007 req0_x / req1_x  in  32  operand from requester n.
REQ-008 req0_rdy / req1_rdy  out  1  operand accepted this cycle; a handshake occurs when vld and rdy are both high.
REQ-009 rsp0_vld / rsp1_vld  out  1  result valid for requester n, single-cycle pulse, no backpressure.
REQ-010 rsp0_y / rsp1_y  out  16  result for requester n.
REQ-011 isqrt_x_vld  out  1  issue strobe to the shared isqrt.
REQ-012 isqrt_x  out  32  operand to the shared isqrt.
REQ-013 isqrt_y_vld  in  1  isqrt result valid.
REQ-014 isqrt_y  in  16  isqrt result.
REQ-015 err  out  1  sticky flag: a result arrived with no operation in flight.
REQ-016 gnt_cnt0 / gnt_cnt1  out  16  per-requester handshake counters; present in both builds.

Function
REQ-017 The arbiter SHALL have two priority states: PRI0 (requester 0 wins a tie) and PRI1 (requester 1 wins a tie). Reset state is PRI0.
REQ-018 A credit SHALL be available when the in-flight count is below DEPTH. A result popped in the same cycle SHALL NOT count towards credit (conservative).
REQ-019 With credit available, req_n_rdy SHALL be high when req_n_vld is high and requester n wins: either it is the only requester valid, or both are valid and the state favours n. rdy SHALL be combinational from vld and state.
REQ-020 After a handshake from requester n, the state SHALL move to favour the other requester. With no handshake, the state SHALL hold.
REQ-021 Without credit, both rdy outputs SHALL be low. At most one handshake SHALL occur per cycle.
REQ-022 isqrt_x_vld and isqrt_x SHALL be registered: asserted in the cycle after the handshake and carrying the accepted operand. When there is no handshake, isqrt_x_vld SHALL be 0 and isqrt_x SHALL hold its value.
REQ-023 On each handshake, the requester id SHALL be pushed into a DEPTH-entry tag FIFO and the in-flight count SHALL be incremented.
REQ-024 On isqrt_y_vld with the FIFO non-empty, the block SHALL pop the FIFO, pulse rsp_vld for the popped id in the same cycle (combinational), and drive that requester's rsp_y with isqrt_y. The in-flight count SHALL be decremented.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order. Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 On isqrt_y_vld with the FIFO empty, the result SHALL be dropped, no rsp_vld SHALL pulse, and err SHALL be set and held until reset.
REQ-027 End-to-end latency SHALL be ISQRT_LAT+1 cycles from handshake to rsp_vld. Sustained throughput SHALL be one handshake per cycle.
REQ-028 rsp_y for the non-selected requester SHALL hold its last value.

Reset
REQ-029 Asserting rst_n low SHALL immediately apply reset values: state PRI0; FIFO empty; count 0; isqrt_x_vld 0; isqrt_x 0; rsp*_vld 0; rsp*_y 0; err 0; gnt_cnt* 0.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight tags. Results arriving after release with no tags in flight SHALL be handled per REQ-026.

Configuration
REQ-031 With ISQRT_ARB_STATS_EN defined, gnt_cnt_n SHALL increment by one on each handshake of requester n and wrap from 0xFFFF to 0.
REQ-032 With ISQRT_ARB_STATS_EN undefined, gnt_cnt0 and gnt_cnt1 SHALL be tied to 0 and no counter registers SHALL exist.

Verification
REQ-033 The bench SHALL check: req0 only, x=144, one cycle -> isqrt_x_vld one cycle later with isqrt_x=144; rsp0_vld with rsp0_y=12 exactly ISQRT_LAT+1 cycles after the handshake; rsp1_vld stays 0.
REQ-034 The bench SHALL check: both requesters valid continuously, req0_x=16 and req1_x=81, 8 cycles -> grants alternate 0,1,0,1,... starting with req0; rsp0_y=4 and rsp1_y=9 alternate; with stats enabled, gnt_cnt0=4 and gnt_cnt1=4.
REQ-035 The bench SHALL check: DEPTH=4, ISQRT_LAT=3, and isqrt_y_vld held low (stalled model) -> after 4 handshakes both rdy are 0; the first isqrt_y_vld pulse restores rdy on the following cycle.
REQ-036 The bench SHALL check: isqrt_y_vld pulsed with no request ever issued -> err=1 and held; no rsp_vld pulses.
REQ-037 The bench SHALL check: rst_n asserted while 3 operations are in flight -> all outputs are at reset values asynchronously, before the next clk edge; after release, the first handshake is granted to req0.
REQ-038 The bench SHALL check: stats enabled, 65537 handshakes on req0 -> gnt_cnt0=1.
